// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate format codes and opcode decode helpers
// for the pipelined RV32I immediate generator.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd7
    } imm_fmt_t;

    function automatic imm_fmt_t decode_fmt(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: decode_fmt = FMT_I;
            OPC_STORE:                     decode_fmt = FMT_S;
            OPC_BRANCH:                    decode_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:            decode_fmt = FMT_U;
            OPC_JAL:                       decode_fmt = FMT_J;
            default:                       decode_fmt = FMT_NONE;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [6:0] opc);
        is_mem_op = (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/imm_assemble.sv
// Combinational RISC-V immediate bit placement: instruction fields + format
// to a sign-extended 32-bit immediate; unknown formats yield zero.
module imm_assemble
    import imm_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_t    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm_o = {instr_i[31:12], 12'b0};
            FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: S1 decodes the opcode, S2
// assembles, sign-extends to XLEN and optionally word-scales memory offsets.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          SCALE_MEM = 1'b1,
    parameter int unsigned MEM_SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [15:0]     imm_count
);

    logic                   s1_valid_q, s1_valid_d;
    logic [31:7]            s1_fields_q, s1_fields_d;
    imm_fmt_t               s1_fmt_q, s1_fmt_d;
    logic                   s1_mem_q, s1_mem_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]        imm_q, imm_d;
    imm_fmt_t               fmt_q, fmt_d;
    logic                   illegal_q, illegal_d;
    logic [15:0]            cnt_q, cnt_d;

    logic                   s2_adv, s1_adv;
    logic [31:0]            asm_imm;
    logic signed [XLEN-1:0] imm_ext;

    imm_assemble u_assemble (
        .instr_i (s1_fields_q),
        .fmt_i   (s1_fmt_q),
        .imm_o   (asm_imm)
    );

    always_comb begin
        s2_adv      = !s2_valid_q || out_ready;
        s1_adv      = !s1_valid_q || s2_adv;

        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        s1_fmt_d    = s1_fmt_q;
        s1_mem_d    = s1_mem_q;
        s2_valid_d  = s2_valid_q;
        imm_d       = imm_q;
        fmt_d       = fmt_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_fields_d = instr[31:7];
                s1_fmt_d    = decode_fmt(instr[6:0]);
                s1_mem_d    = is_mem_op(instr[6:0]);
                cnt_d       = cnt_q + 16'd1;
            end
        end

        // Signed cast sign-extends to XLEN; >>> floors negative offsets.
        imm_ext = XLEN'($signed(asm_imm));
        if (SCALE_MEM && s1_mem_q) begin
            imm_ext = imm_ext >>> MEM_SHIFT;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                imm_d     = imm_ext;
                fmt_d     = s1_fmt_q;
                illegal_d = (s1_fmt_q == FMT_NONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            s1_fmt_q    <= FMT_NONE;
            s1_mem_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            imm_q       <= '0;
            fmt_q       <= FMT_NONE;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fields_q <= s1_fields_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_mem_q    <= s1_mem_d;
            s2_valid_q  <= s2_valid_d;
            imm_q       <= imm_d;
            fmt_q       <= fmt_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign imm       = imm_q;
    assign fmt       = fmt_q;
    assign illegal   = illegal_q;
    assign imm_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 64-bit scaled instance and a 32-bit unscaled instance
// share inputs; all outputs checked against hand-computed immediates.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready, out_valid, illegal;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [15:0] imm_count;

    logic        in_ready0, out_valid0, illegal0;
    logic [31:0] imm0;
    logic [2:0]  fmt0;
    logic [15:0] imm_count0;

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;

    imm_gen_pipe #(.XLEN(64), .SCALE_MEM(1'b1), .MEM_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .illegal(illegal), .imm_count(imm_count)
    );

    imm_gen_pipe #(.XLEN(32), .SCALE_MEM(1'b0), .MEM_SHIFT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .instr(instr), .out_valid(out_valid0), .out_ready(out_ready),
        .imm(imm0), .fmt(fmt0), .illegal(illegal0), .imm_count(imm_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present one instruction; returns at the negedge where its output is valid.
    task automatic run_one(input logic [31:0] ins);
        @(negedge clk);
        instr    = ins;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        instr    = '0;
        check("latency_mid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("out_valid", {63'd0, out_valid}, 64'd1);
    endtask

    localparam logic [31:0] I_LW   = 32'hFF812083;
    localparam logic [31:0] I_SW   = 32'h00512623;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_JAL  = 32'h0010006F;
    localparam logic [31:0] I_LUI  = 32'hABCDE0B7;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_AUI  = 32'h00001097;

    logic [31:0] s_ins [8];
    logic [63:0] s_imm [8];
    logic [2:0]  s_fmt [8];

    initial begin
        s_ins = '{I_LW, I_SW, I_BEQ, I_JAL, I_LUI, I_BAD, I_ADDI, I_AUI};
        s_imm = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'd2048,
                  64'hFFFF_FFFF_ABCD_E000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1000};
        s_fmt = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd7, 3'd0, 3'd3};

        instr     = '0;
        out_ready = 1'b1;
        do_reset();

        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_imm", imm, 64'd0);
        check("rst_fmt", {61'd0, fmt}, 64'd7);
        check("rst_illegal", {63'd0, illegal}, 64'd0);
        check("rst_count", {48'd0, imm_count}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_one(I_LW);
        check("lw_imm_scaled", imm, 64'hFFFF_FFFF_FFFF_FFFE);
        check("lw_imm_raw", {32'd0, imm0}, 64'h0000_0000_FFFF_FFF8);
        check("lw_fmt", {61'd0, fmt}, 64'd0);
        check("lw_illegal", {63'd0, illegal}, 64'd0);

        run_one(I_SW);
        check("sw_imm_scaled", imm, 64'd3);
        check("sw_imm_raw", {32'd0, imm0}, 64'd12);
        check("sw_fmt", {61'd0, fmt}, 64'd1);

        run_one(I_BEQ);
        check("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_fmt", {61'd0, fmt}, 64'd2);

        run_one(I_JAL);
        check("jal_imm", imm, 64'd2048);
        check("jal_fmt", {61'd0, fmt}, 64'd4);

        run_one(I_LUI);
        check("lui_imm64", imm, 64'hFFFF_FFFF_ABCD_E000);
        check("lui_imm32", {32'd0, imm0}, 64'h0000_0000_ABCD_E000);
        check("lui_fmt", {61'd0, fmt}, 64'd3);

        run_one(I_BAD);
        check("bad_illegal", {63'd0, illegal}, 64'd1);
        check("bad_fmt", {61'd0, fmt}, 64'd7);
        check("bad_imm", imm, 64'd0);
        check("bad_imm_raw", {32'd0, imm0}, 64'd0);
        check("count_after_singles", {48'd0, imm_count}, 64'd6);

        // Back-to-back stream with out_ready held high.
        do_reset();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                check($sformatf("stream_valid%0d", t - 2), {63'd0, out_valid}, 64'd1);
                check($sformatf("stream_imm%0d", t - 2), imm, s_imm[t - 2]);
                check($sformatf("stream_fmt%0d", t - 2), {61'd0, fmt}, {61'd0, s_fmt[t - 2]});
            end
            if (t < 8) begin
                instr    = s_ins[t];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream_drained", {63'd0, out_valid}, 64'd0);
        check("stream_count", {48'd0, imm_count}, 64'd8);

        // Backpressure: A, B accepted then stall on C.
        @(negedge clk);
        out_ready = 1'b0;
        instr     = I_LW;
        in_valid  = 1'b1;
        #1 check("bp_ready_a", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        instr = I_SW;
        #1 check("bp_ready_b", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        instr = I_BEQ;
        #1 check("bp_ready_c", {63'd0, in_ready}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("bp_stall_ready%0d", k), {63'd0, in_ready}, 64'd0);
            check($sformatf("bp_stall_valid%0d", k), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp_stall_imm%0d", k), imm, 64'hFFFF_FFFF_FFFF_FFFE);
            check($sformatf("bp_stall_fmt%0d", k), {61'd0, fmt}, 64'd0);
        end
        @(negedge clk);
        check("bp_hold_imm", imm, 64'hFFFF_FFFF_FFFF_FFFE);
        out_ready = 1'b1;
        #1 check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out_b_valid", {63'd0, out_valid}, 64'd1);
        check("bp_out_b_imm", imm, 64'd3);
        @(negedge clk);
        check("bp_out_c_valid", {63'd0, out_valid}, 64'd1);
        check("bp_out_c_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        check("bp_drained", {63'd0, out_valid}, 64'd0);
        check("bp_count", {48'd0, imm_count}, 64'd11);

        // Reset with two instructions in flight.
        @(negedge clk);
        instr    = I_ADDI;
        in_valid = 1'b1;
        @(negedge clk);
        instr = I_LUI;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_pre_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_count", {48'd0, imm_count}, 64'd0);
        check("mid_rst_imm", imm, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_no_stale%0d", k), {63'd0, out_valid}, 64'd0);
        end
        check("mid_count_after", {48'd0, imm_count}, 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
